// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using the shift-add-3 (double dabble) algorithm,
// one bit per clock, with overflow detection and optional leading-zero blanking.
module bin2bcd_seq #(
  parameter int BIN_W = 14,
  parameter int NDIG  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  input  logic                blank_lz,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic [4*NDIG-1:0]   bcd
);

  localparam int SCR_W = 4 * NDIG;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] LIMIT = pow10(NDIG);

  function automatic logic [SCR_W-1:0] add3(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] r;
    r = s;
    for (int k = 0; k < NDIG; k++)
      if (s[4*k +: 4] >= 4'd5) r[4*k +: 4] = s[4*k +: 4] + 4'd3;
    return r;
  endfunction

  // Zero digits above the most significant nonzero digit become 4'hF; digit 0 is never blanked.
  function automatic logic [SCR_W-1:0] blank_zeros(input logic [SCR_W-1:0] s);
    logic [SCR_W-1:0] r;
    logic             seen;
    r    = s;
    seen = 1'b0;
    for (int k = NDIG - 1; k >= 1; k--) begin
      if (s[4*k +: 4] != 4'd0) seen = 1'b1;
      else if (!seen)          r[4*k +: 4] = 4'hF;
    end
    return r;
  endfunction

  typedef enum logic [0:0] {S_IDLE, S_CONV} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_last;
  logic [CNT_W-1:0]   r_cnt;
  logic [SCR_W-1:0]   r_scr;
  logic [BIN_W-1:0]   r_bin_sh;
  logic               r_blank;
  logic               r_ovf_pend;
  logic               r_done;
  logic               r_ovf;
  logic [SCR_W-1:0]   r_bcd;
  logic               w_ovf_in;
  logic [SCR_W-1:0]   w_adj;
  logic [SCR_W-1:0]   w_scr_nxt;
  logic [SCR_W-1:0]   w_result;

  assign w_ovf_in = (64'(bin) >= LIMIT);

  // The carry out of the top digit falls off in the truncating cast.
  assign w_adj     = add3(r_scr);
  assign w_scr_nxt = SCR_W'({w_adj, r_bin_sh[BIN_W-1]});
  assign w_result  = r_ovf_pend ? {SCR_W{1'b1}}
                   : (r_blank ? blank_zeros(w_scr_nxt) : w_scr_nxt);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        if (r_cnt == CNT_W'(1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_scr      <= '0;
      r_bin_sh   <= '0;
      r_blank    <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_bcd      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      if (w_accept) begin
        r_bin_sh   <= bin;
        r_blank    <= blank_lz;
        r_scr      <= '0;
        r_cnt      <= CNT_W'(BIN_W);
        r_ovf_pend <= w_ovf_in;
      end else if (r_state == S_CONV) begin
        r_scr    <= w_scr_nxt;
        r_bin_sh <= r_bin_sh << 1;
        r_cnt    <= r_cnt - CNT_W'(1);
        if (w_last) begin
          r_done <= 1'b1;
          r_ovf  <= r_ovf_pend;
          r_bcd  <= w_result;
        end
      end
    end
  end

  assign busy = (r_state == S_CONV);
  assign done = r_done;
  assign ovf  = r_ovf;
  assign bcd  = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases plus randomized conversions
// compared against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

  localparam int BIN_W = 14;
  localparam int NDIG  = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic [BIN_W-1:0]  bin;
  logic              blank_lz;
  logic              busy;
  logic              done;
  logic              ovf;
  logic [4*NDIG-1:0] bcd;

  int n_cmp;
  int n_err;

  bin2bcd_seq #(.BIN_W(BIN_W), .NDIG(NDIG)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .blank_lz (blank_lz),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf),
    .bcd      (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: decimal digits by division, then blank zeros above the leading digit.
  function automatic logic [15:0] model_bcd(input int v, input bit blz);
    logic [15:0] r;
    int          d [4];
    int          msd;
    int          p;
    if (v >= 10000) return 16'hFFFF;
    p   = 1;
    msd = 0;
    for (int k = 0; k < 4; k++) begin
      d[k] = (v / p) % 10;
      p    = p * 10;
      if (d[k] != 0) msd = k;
    end
    for (int k = 0; k < 4; k++) begin
      if (blz && k > 0 && k > msd) r[4*k +: 4] = 4'hF;
      else                         r[4*k +: 4] = 4'(d[k]);
    end
    return r;
  endfunction

  function automatic logic model_ovf(input int v);
    return (v >= 10000);
  endfunction

  // Called just after a negedge with the DUT idle; returns just after the negedge following done.
  task automatic convert(input int v, input bit blz, input bit check_busy);
    start    = 1'b1;
    bin      = BIN_W'(v);
    blank_lz = blz;
    @(posedge clk);
    #1;
    start    = 1'b0;
    bin      = '0;
    blank_lz = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (check_busy) chk("busy_conv", 32'(busy), 32'd1);
      if (done) chk("early_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk($sformatf("bcd_%0d_%0d", v, blz), 32'(bcd), 32'(model_bcd(v, blz)));
    chk($sformatf("ovf_%0d", v), 32'(ovf), 32'(model_ovf(v)));
    @(negedge clk);
    chk("done_single", 32'(done), 32'd0);
    chk("bcd_hold", 32'(bcd), 32'(model_bcd(v, blz)));
  endtask

  initial begin
    int cyc;
    int ndone;
    logic [15:0] cap;
    int v;
    bit blz;

    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    start    = 1'b1;
    bin      = BIN_W'(1234);
    blank_lz = 1'b0;

    // Reset held two cycles with start asserted
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_bcd", 32'(bcd), 32'h0);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);

    // Basic conversions and overflow
    convert(1234, 1'b0, 1'b1);
    convert(0, 1'b0, 1'b1);
    convert(9999, 1'b0, 1'b1);
    convert(16383, 1'b0, 1'b1);
    convert(10000, 1'b0, 1'b0);
    convert(16383, 1'b1, 1'b0);

    // Blanking
    convert(7, 1'b1, 1'b0);
    convert(0, 1'b1, 1'b0);
    convert(1005, 1'b1, 1'b0);
    convert(40, 1'b1, 1'b0);
    convert(40, 1'b0, 1'b0);

    // Start during CONV must be ignored
    start = 1'b1;
    bin   = BIN_W'(4321);
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    cap   = '0;
    for (cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (cyc == 5) begin
        start = 1'b1;
        bin   = BIN_W'(9876);
      end else if (cyc == 6) begin
        start = 1'b0;
        bin   = '0;
      end
      if (done) begin
        ndone++;
        cap = bcd;
        chk("ign_latency", 32'(cyc), 32'd15);
      end
    end
    chk("ign_ndone", 32'(ndone), 32'd1);
    chk("ign_bcd", 32'(cap), 32'h4321);

    // Back-to-back with start held high
    start    = 1'b1;
    bin      = BIN_W'(12);
    blank_lz = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk);
      #1;
      bin = (n % 2 == 0) ? BIN_W'(345) : BIN_W'(12);
      for (int k = 0; k < 14; k++) begin
        @(negedge clk);
        chk("b2b_busy", 32'(busy), 32'd1);
      end
      @(negedge clk);
      chk("b2b_done", 32'(done), 32'd1);
      chk("b2b_busy_lo", 32'(busy), 32'd0);
      chk("b2b_bcd", 32'(bcd), (n % 2 == 0) ? 32'h0012 : 32'h0345);
      if (n == 3) start = 1'b0;
    end
    @(negedge clk);
    chk("b2b_stop", 32'(busy), 32'd0);

    // Reset in the middle of a conversion
    start = 1'b1;
    bin   = BIN_W'(5678);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 7; k++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_bcd", 32'(bcd), 32'h0);
    chk("mrst_ovf", 32'(ovf), 32'd0);
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("mrst_nodone", 32'(ndone), 32'd0);
    convert(5678, 1'b0, 1'b1);

    // Randomized conversions
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(10000, 16383));
      else if ($urandom_range(0, 1) == 0) v = int'($urandom_range(0, 120));
      else v = int'($urandom_range(0, 9999));
      blz = 1'($urandom_range(0, 1));
      convert(v, blz, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
